// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared store-entry type and address constants for the store buffer
package mem_pkg;

   localparam int SB_DEPTH = 4;
   localparam int WORD_MSB = 31;
   localparam int WORD_LSB = 2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] wd;
      logic        bytemode;
   } sb_entry_t;

   function automatic logic same_word(input logic [31:0] x, input logic [31:0] y);
      return x[WORD_MSB:WORD_LSB] == y[WORD_MSB:WORD_LSB];
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-side and memory-side signals of the store buffer
interface store_buffer_if;

   logic        cpu_we;
   logic        cpu_re;
   logic        cpu_bytemode;
   logic [31:0] cpu_a;
   logic [31:0] cpu_wd;
   logic [31:0] cpu_rd;
   logic        cpu_stall;
   logic        mem_we;
   logic        mem_bytemode;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  cpu_we, cpu_re, cpu_bytemode, cpu_a, cpu_wd, mem_rd,
      output cpu_rd, cpu_stall, mem_we, mem_bytemode, mem_a, mem_wd
   );

   modport master (
      output cpu_we, cpu_re, cpu_bytemode, cpu_a, cpu_wd, mem_rd,
      input  cpu_rd, cpu_stall, mem_we, mem_bytemode, mem_a, mem_wd
   );

endinterface

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - circular store-entry queue exposing every slot for address compare
module store_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  sb_entry_t        entry_i,
   output sb_entry_t        head_o,
   output sb_entry_t        entries_o [DEPTH],
   output logic [DEPTH-1:0] valid_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = $clog2(DEPTH);

   sb_entry_t        slot_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             empty_q, empty_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      if (pop_i) begin
         head_d          = head_q + PW'(1);
         valid_d[head_q] = 1'b0;
      end
      if (push_i) begin
         tail_d          = tail_q + PW'(1);
         valid_d[tail_q] = 1'b1;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         empty_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         empty_q <= empty_d;
      end
   end

   // Slot contents need no reset: valid_q gates every use of them.
   always_ff @(posedge clk) begin
      if (push_i) slot_q[tail_q] <= entry_i;
   end

   assign entries_o = slot_q;
   assign head_o    = slot_q[head_q];
   assign valid_o   = valid_q;
   assign count_o   = count_q;
   assign empty_o   = empty_q;
   assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer arbitrating the data-memory port between loads and drains
module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus,
   output logic          empty,
   output logic [CW-1:0] count
);

   sb_entry_t        head_entry;
   sb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid;
   logic             full;
   logic             fifo_empty;
   logic             match_any;
   logic             hit;
   logic             push;
   logic             drain;
   sb_entry_t        new_entry;

   assign new_entry = '{a: bus.cpu_a, wd: bus.cpu_wd, bytemode: bus.cpu_bytemode};

   store_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push),
      .pop_i     (drain),
      .entry_i   (new_entry),
      .head_o    (head_entry),
      .entries_o (entries),
      .valid_o   (valid),
      .full_o    (full),
      .empty_o   (fifo_empty),
      .count_o   (count)
   );

   always_comb begin
      match_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && same_word(entries[i].a, bus.cpu_a)) match_any = 1'b1;
      end
   end

   // A simultaneous store wins over the load for hazard purposes, but the load still owns the port.
   assign hit   = bus.cpu_re & ~bus.cpu_we & match_any;
   assign push  = ~reset & bus.cpu_we & ~full;
   assign drain = ~reset & ~fifo_empty & (~bus.cpu_re | hit);

   assign bus.cpu_stall = ~reset & ((bus.cpu_we & full) | hit);
   assign empty         = reset | fifo_empty;

   always_comb begin
      bus.mem_we       = 1'b0;
      bus.mem_a        = bus.cpu_a;
      bus.mem_wd       = bus.cpu_wd;
      bus.mem_bytemode = 1'b0;
      bus.cpu_rd       = bus.mem_rd;
      if (drain) begin
         bus.mem_we       = 1'b1;
         bus.mem_a        = head_entry.a;
         bus.mem_wd       = head_entry.wd;
         bus.mem_bytemode = head_entry.bytemode;
         bus.cpu_rd       = 32'h0;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        empty;
   logic [2:0]  count;
   logic [31:0] mem [128];
   logic [31:0] wr_log [$];
   logic [31:0] exp_order [5];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   store_buffer_if bus ();

   store_buffer #(.DEPTH(4), .CW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .empty (empty),
      .count (count)
   );

   // Big-endian byte lanes: byte offset 0 lives in bits 31:24.
   assign bus.mem_rd = mem[bus.mem_a[8:2]];

   always @(posedge clk) begin
      if (bus.mem_we) begin
         wr_log.push_back(bus.mem_a);
         if (bus.mem_bytemode)
            mem[bus.mem_a[8:2]][8*(3-int'(bus.mem_a[1:0])) +: 8] = bus.mem_wd[7:0];
         else
            mem[bus.mem_a[8:2]] = bus.mem_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic re, input logic bm,
                        input logic [31:0] a, input logic [31:0] wd);
      bus.cpu_we       = we;
      bus.cpu_re       = re;
      bus.cpu_bytemode = bm;
      bus.cpu_a        = a;
      bus.cpu_wd       = wd;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[16] = 32'hCAFEF00D;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      #1;
      check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      check("rst_stall", {31'b0, bus.cpu_stall}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("idle_mem_we", {31'b0, bus.mem_we}, 32'd0);
      check("idle_empty", {31'b0, empty}, 32'd1);
      check("idle_count", {29'b0, count}, 32'd0);
      check("idle_stall", {31'b0, bus.cpu_stall}, 32'd0);

      // single word store, drained on the following cycle
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
      #1;
      check("st1_stall", {31'b0, bus.cpu_stall}, 32'd0);
      check("st1_no_bypass", {31'b0, bus.mem_we}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("st1_count", {29'b0, count}, 32'd1);
      check("st1_mem_we", {31'b0, bus.mem_we}, 32'd1);
      check("st1_mem_a", bus.mem_a, 32'h10);
      check("st1_mem_wd", bus.mem_wd, 32'hDEADBEEF);
      tick();
      check("st1_mem4", mem[4], 32'hDEADBEEF);
      check("st1_empty", {31'b0, empty}, 32'd1);
      check("st1_idle_we", {31'b0, bus.mem_we}, 32'd0);

      // fill to full with the port held by loads, then overflow store
      wr_log.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h100 + 32'(i));
         #1;
         check($sformatf("fill%0d_stall", i), {31'b0, bus.cpu_stall}, 32'd0);
         tick();
      end
      check("fill_count", {29'b0, count}, 32'd4);
      drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h55);
      #1;
      check("full_stall", {31'b0, bus.cpu_stall}, 32'd1);
      check("full_no_drain", {31'b0, bus.mem_we}, 32'd0);
      tick();
      check("full_count_hold", {29'b0, count}, 32'd4);
      bus.cpu_re = 1'b0;
      #1;
      check("full_drain_stall", {31'b0, bus.cpu_stall}, 32'd1);
      check("full_drain_we", {31'b0, bus.mem_we}, 32'd1);
      check("full_drain_a", bus.mem_a, 32'h0);
      tick();
      check("after_drain_count", {29'b0, count}, 32'd3);
      check("accept_stall", {31'b0, bus.cpu_stall}, 32'd0);
      check("accept_drain_a", bus.mem_a, 32'h4);
      tick();
      check("enq_deq_count", {29'b0, count}, 32'd3);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 8 && !empty; i++) tick();
      check("fill_drained", {31'b0, empty}, 32'd1);
      exp_order = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h30};
      check("order_len", 32'(wr_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("order%0d", i), (i < wr_log.size()) ? wr_log[i] : 32'hFFFFFFFF, exp_order[i]);
      check("fill_mem3", mem[3], 32'h103);
      check("fill_mem12", mem[12], 32'h55);

      // byte store followed by a load of the same word
      drive(1'b1, 1'b0, 1'b1, 32'h21, 32'h5A);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      check("hit_stall", {31'b0, bus.cpu_stall}, 32'd1);
      check("hit_drain_we", {31'b0, bus.mem_we}, 32'd1);
      check("hit_drain_a", bus.mem_a, 32'h21);
      check("hit_drain_bm", {31'b0, bus.mem_bytemode}, 32'd1);
      check("hit_rd_zero", bus.cpu_rd, 32'h0);
      tick();
      check("hit_clear", {31'b0, bus.cpu_stall}, 32'd0);
      check("hit_rd", bus.cpu_rd, 32'h005A0000);

      // load to another word while a store waits
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h77);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      check("miss_stall", {31'b0, bus.cpu_stall}, 32'd0);
      check("miss_we", {31'b0, bus.mem_we}, 32'd0);
      check("miss_rd", bus.cpu_rd, 32'hCAFEF00D);
      tick();
      check("miss_deferred", {29'b0, count}, 32'd1);
      bus.cpu_re = 1'b0;
      #1;
      check("deferred_a", bus.mem_a, 32'h80);
      tick();
      check("deferred_mem", mem[32], 32'h77);
      check("deferred_empty", {31'b0, empty}, 32'd1);

      // reset discards pending stores
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
         tick();
      end
      check("pre_rst_count", {29'b0, count}, 32'd3);
      wr_log.delete();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("inrst_we", {31'b0, bus.mem_we}, 32'd0);
      check("inrst_empty", {31'b0, empty}, 32'd1);
      tick();
      reset = 1'b0;
      #1;
      check("postrst_count", {29'b0, count}, 32'd0);
      check("postrst_we", {31'b0, bus.mem_we}, 32'd0);
      tick();
      tick();
      tick();
      check("rst_no_writes", 32'(wr_log.size()), 32'd0);
      check("rst_mem64", mem[64], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
